pool_window_feeder: RTL
=======================

# pool_window_feeder

Streaming front end that drives the 2x2 average-pooling unit. Accepts a feature map one pixel per valid cycle in row-major order and buffers one line. It assembles each non-overlapping 2x2 window (stride 2), issues it to the pooler with a single-cycle `pool_start` pulse, and captures the pooler's 14-bit result into an output stream with a frame-done marker.

## Interface
- `W`, default 28: feature-map width in pixels; even, ≥2.
- `H`, default 28: feature-map height in rows; even, ≥2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_pixel` is valid this cycle; always accepted, no backpressure.
- `in_pixel`, input, 16: signed pixel (shortint).
- `pool_start`, output, 1: one-cycle start pulse to the pooler.
- `win_00`, `win_01`, `win_10`, `win_11`, output, 16 each: window pixels as `[row][col]` offsets within the window.
- `pool_finish`, input, 1: pooler finish (follows `pool_start`).
- `pool_pixel`, input, 14: pooler result.
- `out_valid`, output, 1: `out_pixel` is valid; one-cycle pulse.
- `out_pixel`, output, 14: pooled pixel, row-major over the (H/2)x(W/2) output map.
- `out_last`, output, 1: high with the final `out_valid` of a frame.

## Operation
- Counters:
  - `col` counts 0..W-1 and wraps to 0 at W-1.
  - `row` counts 0..H-1; it increments on each `col` wrap and wraps to 0 after (H-1, W-1).
  - Both advance only on accepted pixels (`in_valid`=1).
- Line buffer: W x 16 bits. On even rows, each pixel is written to `line[col]`. On odd rows the buffer is read only.
- Hold register `prev`: latches every accepted pixel at even `col`.
- Window issue: triggered by a pixel accepted at odd `row` and odd `col`. On that edge, register:
  - `win_00`=`line[col-1]`, `win_01`=`line[col]`
  - `win_10`=`prev`, `win_11`=`in_pixel`
  - `pool_start` set to 1
- `pool_start` clears on the following edge unconditionally.
  - Windows are at least 2 accepted pixels apart, so `pool_start` always returns low for at least 1 cycle between pulses. This gives the pooler a clean rising edge per window.
  - Never hold `pool_start` high for 2 consecutive cycles.
- Capture: on any edge where the registered `pool_start` and `pool_finish` are both sampled high, register:
  - `out_pixel` ← `pool_pixel`
  - `out_valid` ← 1
  - `out_last` ← 1 if the window was issued for (row H-1, col W-1)
- `out_valid` and `out_last` clear on the next edge.
- If `pool_finish` is low at that edge, nothing is captured. This is a pooler fault: the window is dropped, and counters and frame progress continue.
- States (tracked by `row` parity):
  - `FILL`: even row; buffer writes, no issue.
  - `ISSUE`: odd row; issue on odd columns.
  - Transitions happen on `col` wrap. After the last pixel of the frame, return to `FILL` with `row`=`col`=0; the next frame follows immediately with no idle cycles needed.
- Arithmetic: this block does none. Width reduction to 14 bits is the pooler's; `out_pixel` is passed through unmodified.

## Timing
- Reset values: `pool_start`=0, `out_valid`=0, `out_last`=0, `win_*`=0, `out_pixel`=0, `row`=0, `col`=0, `prev`=0. Line buffer contents are don't-care.
- Latency: window-completing pixel accepted at edge E0 → `pool_start` high in cycle E0..E1 → result captured at E1 → `out_valid` high in cycle E1..E2. Two edges from acceptance to valid output.
- Gaps in `in_valid` stall the counters only. An in-flight issue/capture completes regardless of `in_valid`.
- Reset asserted mid-frame: all registers go to their reset values immediately (asynchronous). A pending `pool_start` or `out_valid` is cancelled. The first pixel after release is treated as (0,0).
- Throughput: one output per 2 input pixels on odd rows; none on even rows.

## Test plan
- W=H=4, frame 1..16 row-major, continuous `in_valid`, pooler model → `out_pixel` = 3, 5, 11, 13. `out_last` is set only with 13. Each `out_valid` occurs exactly 2 edges after acceptance of pixels 6, 8, 14, 16.
- Same frame with `in_valid` low every other cycle → identical outputs. `pool_start` pulses stay 1 cycle wide with low gaps between them.
- Two back-to-back frames (1..16, then all 400) → 3, 5, 11, 13, then 400 ×4, with `out_last` on the 4th and 8th outputs. No idle cycles are needed between frames.
- Negative data, all pixels −8 → `win_*`=16'hFFF8. `out_pixel` equals the 14-bit truncation the pooler returns: 14'h3FF8.
- Assert `rst_n`=0 one cycle after pixel 6 is accepted (`pool_start` high) → `pool_start` and `out_valid` drop at once and no output is produced. After release, a full 1..16 frame yields 3, 5, 11, 13.
- Hold `pool_finish`=0 for the second window → only 3 outputs (3, 11, 13). `out_last` still fires on 13.

Source files
------------

// File: rtl/pool_window_feeder.sv
// Purpose : streaming 2x2/stride-2 window assembler for the average pooler, plus result capture.
// Latency : 2 edges from the window-completing pixel to out_valid (1 edge to pool_start).
// Backpres: none; every in_valid pixel is accepted, and a window is dropped if pool_finish is low.
//
// Ports: clk/rst_n (async active-low); in_valid/in_pixel pixel stream (row-major, signed 16b);
//        pool_start + win_00..win_11 to the pooler; pool_finish/pool_pixel back from it;
//        out_valid/out_pixel/out_last pooled output stream with end-of-frame marker.
module pool_window_feeder #(
    parameter int W = 28,
    parameter int H = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_pixel,
    output logic        pool_start,
    output logic [15:0] win_00,
    output logic [15:0] win_01,
    output logic [15:0] win_10,
    output logic [15:0] win_11,
    input  logic        pool_finish,
    input  logic [13:0] pool_pixel,
    output logic        out_valid,
    output logic [13:0] out_pixel,
    output logic        out_last
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam int RW = (H > 2) ? $clog2(H) : 1;

    // FILL = even row (buffer the line), ISSUE = odd row (emit windows)
    typedef enum logic {FILL, ISSUE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            issue;
    logic            col_wrap;
    logic            frame_end;

    logic [15:0]     line_q [W];
    logic [15:0]     prev_q;
    logic [15:0]     win_00_q, win_01_q, win_10_q, win_11_q;
    logic            pool_start_q;
    logic            last_win_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [13:0]     out_pixel_q;
    logic            capture;

    assign col_wrap  = in_valid && (col_q == CW'(W - 1));
    assign frame_end = col_wrap && (row_q == RW'(H - 1));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        issue   = 1'b0;
        if (in_valid) begin
            issue = (state_q == ISSUE) && col_q[0];
            if (col_wrap) begin
                col_d = '0;
                if (frame_end) begin
                    row_d   = '0;
                    state_d = FILL;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = (state_q == FILL) ? ISSUE : FILL;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Line storage is don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        if (in_valid && (state_q == FILL)) begin
            line_q[col_q] <= in_pixel;
        end
    end

    // The pooler answers combinationally while pool_start is high, so the
    // capture decision uses the registered start and the live finish.
    assign capture = pool_start_q && pool_finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= '0;
            win_00_q     <= '0;
            win_01_q     <= '0;
            win_10_q     <= '0;
            win_11_q     <= '0;
            pool_start_q <= 1'b0;
            last_win_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_pixel_q  <= '0;
        end else begin
            if (in_valid && !col_q[0]) begin
                prev_q <= in_pixel;
            end
            // Windows are >= 2 accepted pixels apart, so this is always a 1-cycle pulse.
            pool_start_q <= issue;
            if (issue) begin
                // col_q is odd here, so col-1 is col with bit 0 cleared.
                win_00_q   <= line_q[{col_q[CW-1:1], 1'b0}];
                win_01_q   <= line_q[col_q];
                win_10_q   <= prev_q;
                win_11_q   <= in_pixel;
                last_win_q <= frame_end;
            end
            out_valid_q <= capture;
            out_last_q  <= capture && last_win_q;
            if (capture) begin
                out_pixel_q <= pool_pixel;
            end
        end
    end

    assign pool_start = pool_start_q;
    assign win_00     = win_00_q;
    assign win_01     = win_01_q;
    assign win_10     = win_10_q;
    assign win_11     = win_11_q;
    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign out_last   = out_last_q;

endmodule
